// File: rtl/mips_pipe_mult_param.sv
// Purpose: pipelined MIPS MULT/MULTU unit that carries a destination tag with each operation.
// Latency: STAGES cycles from issue to done, and it accepts one issue per cycle.
// Backpressure: stall freezes every stage and refuses issue; flush kills all in-flight operations.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   start, is_signed, tag    issue request, MULT/MULTU select, destination tag
//   src_a, src_b             operands
//   stall, flush             hold the pipeline / kill everything in flight (flush wins)
//   done, done_tag           one-cycle completion pulse and the tag of that operation
//   mult_lower, mult_higher  LO/HI product halves, held until the next completion
//   busy, in_flight          any stage valid / number of valid stages
module mips_pipe_mult_param #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        is_signed,
    input  logic [TAG_W-1:0]            tag,
    input  logic [DATA_W-1:0]           src_a,
    input  logic [DATA_W-1:0]           src_b,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        done,
    output logic [TAG_W-1:0]            done_tag,
    output logic [DATA_W-1:0]           mult_lower,
    output logic [DATA_W-1:0]           mult_higher,
    output logic                        busy,
    output logic [$clog2(STAGES+1)-1:0] in_flight
);
    localparam int CNT_W = $clog2(STAGES+1);
    localparam int LAST  = STAGES - 1;
    localparam int PW    = 2 * DATA_W;

    generate
        if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
            $error("mips_pipe_mult_param: STAGES must be in 1..8");
        end
    endgenerate

    // Extending both operands to 2*DATA_W makes a single truncated multiply
    // correct for both MULT (sign extension) and MULTU (zero extension).
    logic [PW-1:0] w_ext_a;
    logic [PW-1:0] w_ext_b;
    logic [PW-1:0] w_prod;

    assign w_ext_a = {{DATA_W{is_signed & src_a[DATA_W-1]}}, src_a};
    assign w_ext_b = {{DATA_W{is_signed & src_b[DATA_W-1]}}, src_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Stage STAGES-1 is the output register. Its data fields double as the
    // held result, so they load only when a valid operation arrives.
    logic [STAGES-1:0] r_vld;
    logic [TAG_W-1:0]  r_tag  [0:STAGES-1];
    logic [PW-1:0]     r_prod [0:STAGES-1];
    logic              r_done;

    logic [STAGES-1:0] w_in_vld;
    logic [TAG_W-1:0]  w_in_tag  [0:STAGES-1];
    logic [PW-1:0]     w_in_prod [0:STAGES-1];
    logic [CNT_W-1:0]  w_cnt;

    always_comb begin
        w_in_vld     = '0;
        w_in_vld[0]  = start;
        w_in_tag[0]  = tag;
        w_in_prod[0] = w_prod;
        for (int s = 1; s < STAGES; s++) begin
            w_in_vld[s]  = r_vld[s-1];
            w_in_tag[s]  = r_tag[s-1];
            w_in_prod[s] = r_prod[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld  <= '0;
            r_done <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                r_tag[s]  <= '0;
                r_prod[s] <= '0;
            end
        end else if (flush) begin
            // Result fields stay put so the last completed value remains visible.
            r_vld  <= '0;
            r_done <= 1'b0;
        end else if (stall) begin
            // The stages hold, but a completion is only ever reported once.
            r_done <= 1'b0;
        end else begin
            r_vld  <= w_in_vld;
            r_done <= w_in_vld[LAST];
            for (int s = 0; s < LAST; s++) begin
                r_tag[s]  <= w_in_tag[s];
                r_prod[s] <= w_in_prod[s];
            end
            if (w_in_vld[LAST]) begin
                r_tag[LAST]  <= w_in_tag[LAST];
                r_prod[LAST] <= w_in_prod[LAST];
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_cnt = w_cnt + CNT_W'(r_vld[s]);
        end
    end

    assign done        = r_done;
    assign done_tag    = r_tag[LAST];
    assign mult_lower  = r_prod[LAST][DATA_W-1:0];
    assign mult_higher = r_prod[LAST][PW-1:DATA_W];
    assign busy        = |r_vld;
    assign in_flight   = w_cnt;

endmodule

// File: doc/mips_pipe_mult_param.md
MIPS_PIPE_MULT_PARAM -- requirements
Module: mips_pipe_mult_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width in bits.
REQ-002 SHALL have parameter STAGES, default 4, total register depth from operand capture to result, legal range 1..8.
REQ-003 SHALL have parameter TAG_W, default 5, width of the per-operation destination tag.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  request to issue a multiply this cycle.
REQ-007 SHALL have port is_signed  input  1  1 = MULT (two's complement), 0 = MULTU.
REQ-008 SHALL have port tag  input  TAG_W  identifier carried with the operation.
REQ-009 SHALL have port src_a  input  DATA_W  multiplicand.
REQ-010 SHALL have port src_b  input  DATA_W  multiplier.
REQ-011 SHALL have port stall  input  1  hold every pipeline stage and refuse issue.
REQ-012 SHALL have port flush  input  1  kill all in-flight operations.
REQ-013 SHALL have port done  output  1  one-cycle pulse, result valid on mult_lower/mult_higher.
REQ-014 SHALL have port done_tag  output  TAG_W  tag of the completing operation.
REQ-015 SHALL have port mult_lower  output  DATA_W  product bits [DATA_W-1:0] (LO).
REQ-016 SHALL have port mult_higher  output  DATA_W  product bits [2*DATA_W-1:DATA_W] (HI).
REQ-017 SHALL have port busy  output  1  high while any stage holds a valid operation.
REQ-018 SHALL have port in_flight  output  $clog2(STAGES+1)  count of valid operations in stages.

Function
REQ-019 SHALL accept an operation on a rising edge when start=1, stall=0, flush=0; otherwise start is ignored (no queuing).
REQ-020 SHALL compute a full 2*DATA_W product; is_signed=1 sign-extends both operands, is_signed=0 zero-extends.
REQ-021 SHALL carry valid, tag and product through STAGES registers, the last being the output register; STAGES=1 means output register only.
REQ-022 SHALL, with no stall, assert done in cycle t+STAGES for an operation issued in cycle t (STAGES=4: issue cycle 0, done cycle 4).
REQ-023 SHALL, while stall=1, hold all stage contents and valid bits unchanged, and deassert done; each stall cycle adds exactly one cycle of latency.
REQ-024 SHALL, when the last stage advances with a valid operation, load mult_lower, mult_higher, done_tag and pulse done for exactly one cycle.
REQ-025 SHALL hold mult_lower, mult_higher, done_tag at the last completed result until the next completion (not zero when idle).
REQ-026 SHALL sustain one issue per cycle; back-to-back operations complete on consecutive cycles in issue order.
REQ-027 SHALL, on flush=1 at a rising edge, clear every valid bit including an issue sampled the same edge; done=0 next cycle; result outputs retain the previous values.
REQ-028 SHALL give flush priority over stall and start.
REQ-029 SHALL make busy = OR of stage valid bits and in_flight = their population count, both updated with the stage registers.
REQ-030 SHALL treat out-of-range STAGES as an elaboration error.

Reset
REQ-031 SHALL, on rst=0, asynchronously clear all valid bits, done, done_tag, mult_lower, mult_higher to 0; busy=0, in_flight=0.
REQ-032 SHALL discard in-flight operations at reset; no done is produced for them after release.
REQ-033 SHALL accept a new operation on the first rising edge with rst=1.

Verification
REQ-034 SHALL cover: STAGES=4, DATA_W=32, signed 0xFFFFFFFF*0x00000001 issued cycle 0 -> done cycle 4, HI=0xFFFFFFFF, LO=0xFFFFFFFF; same operands unsigned -> HI=0x00000000, LO=0xFFFFFFFF.
REQ-035 SHALL cover: four back-to-back issues tags 1..4 (3*5, 7*7, 0*9, 0xFFFF*0xFFFF unsigned) -> done cycles 4..7, LO=15,49,0,0xFFFE0001, tags 1..4, in_flight peaks at 4.
REQ-036 SHALL cover: issue cycle 0, stall high cycles 2-3 -> done cycle 6, done low during stall, start during stall ignored.
REQ-037 SHALL cover: issue cycles 0-1, flush cycle 2 with start=1 -> no done ever, busy=0 cycle 3, outputs keep prior result.
REQ-038 SHALL cover: rst=0 asserted mid-cycle with 3 in flight -> outputs 0 immediately, no done after release; STAGES=1 run -> done cycle 1.
